// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam logic [31:0] MIN_NEG       = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv,
        StDone
    } state_e;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for multdiv: synchronous clear, saturates at WIDTH.
module multdiv_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o,
    output logic done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !done_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // last_o marks the edge that performs the final iteration.
    assign last_o = (count_q == CNT_W'(WIDTH - 1));
    assign done_o = (count_q == CNT_W'(WIDTH));

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit with a
// one-cycle ready pulse; both datapaths share a single 2*WIDTH+1-bit work register.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] MinNegW = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e             state_q, state_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic cnt_clr, cnt_en, cnt_last, cnt_done;

    multdiv_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk_i  (clock),
        .rst_ni (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_o (cnt_last),
        .done_o (cnt_done)
    );

    // Booth step: accumulator widened by one bit so a most-negative
    // multiplicand cannot overflow before the arithmetic shift.
    logic [WIDTH:0]   booth_acc, booth_mcand, booth_sum;
    logic [2*WIDTH:0] booth_next;
    logic [WIDTH:0]   booth_hi;
    logic             booth_ovf;

    always_comb begin
        booth_acc   = {work_q[2*WIDTH], work_q[2*WIDTH:WIDTH+1]};
        booth_mcand = {mcand_q[WIDTH-1], mcand_q};
        unique case (work_q[1:0])
            2'b01:   booth_sum = booth_acc + booth_mcand;
            2'b10:   booth_sum = booth_acc - booth_mcand;
            default: booth_sum = booth_acc;
        endcase
        booth_next = {booth_sum, work_q[WIDTH:1]};
        booth_hi   = booth_next[2*WIDTH:WIDTH];
        booth_ovf  = !((booth_hi == '0) || (booth_hi == '1));
    end

    // Restoring divide step: remainder in the upper WIDTH+1 bits, quotient below.
    logic [WIDTH:0]   div_shift, div_trial;
    logic [2*WIDTH:0] div_next;
    logic [WIDTH-1:0] div_quo;

    always_comb begin
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        if (div_trial[WIDTH]) begin
            div_next = {div_shift, work_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial, work_q[WIDTH-2:0], 1'b1};
        end
        div_quo = div_next[WIDTH-1:0];
    end

    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign cnt_en = ((state_q == StMult) || (state_q == StDiv)) && !cnt_done;

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = 1'b0;
        rdy_d    = 1'b0;
        cnt_clr  = 1'b0;

        if (ctrl_MULT) begin
            cnt_clr = 1'b1;
            state_d = StMult;
            work_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
            mcand_d = data_operandA;
        end else if (ctrl_DIV) begin
            cnt_clr = 1'b1;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf_d   = (data_operandA == MinNegW) && (data_operandB == '1);
            work_d  = {{(WIDTH + 1){1'b0}}, a_mag};
            mcand_d = b_mag;
            // Zero divisor skips the iterations; DONE raises the pulse next edge.
            state_d = (data_operandB == '0) ? StDone : StDiv;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StMult: begin
                    work_d = booth_next;
                    if (cnt_last) begin
                        state_d  = StDone;
                        result_d = booth_next[WIDTH:1];
                        exc_d    = booth_ovf;
                        rdy_d    = 1'b1;
                    end
                end
                StDiv: begin
                    work_d = div_next;
                    if (cnt_last) begin
                        state_d  = StDone;
                        result_d = neg_q ? -div_quo : div_quo;
                        exc_d    = ovf_q;
                        rdy_d    = 1'b1;
                    end
                end
                StDone: begin
                    if (rdy_q) begin
                        state_d = StIdle;
                    end else begin
                        // Arrived straight from a zero-divisor start.
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            work_q   <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv: latency, results, exceptions,
// restart and asynchronous reset behaviour with hand-computed expectations.
module tb_multdiv;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        ctrl_mult = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    multdiv #(
        .WIDTH (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (ctrl_mult),
        .ctrl_DIV       (ctrl_div),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clock);
        opa       = a;
        opb       = b;
        ctrl_mult = m;
        ctrl_div  = d;
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        opa       = 32'hDEAD_BEEF;
        opb       = 32'h1234_5678;
    endtask

    task automatic wait_ready(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_rdy(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        start_op(m, d, a, b);
        wait_ready(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, data_result, exp_res);
        check({tag, " exception"}, 32'(data_exception), 32'(exp_exc));
        @(posedge clock);
        #1;
        check({tag, " rdy drop"}, 32'(data_resultRDY), 32'd0);
        check({tag, " exc drop"}, 32'(data_exception), 32'd0);
        check({tag, " result hold"}, data_result, exp_res);
    endtask

    initial begin
        int cnt;

        #12;
        check("reset result", data_result, 32'd0);
        check("reset exception", 32'(data_exception), 32'd0);
        check("reset rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32, 32'hFFFF_FFEB, 1'b0);
        run_op("mul ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32, 32'h0, 1'b1);
        run_op("mul -5*-6", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32, 32'h1E, 1'b0);
        run_op("mul minneg*-1", 1'b1, 1'b0, MIN_NEG, 32'hFFFF_FFFF, 32, 32'h8000_0000, 1'b1);
        run_op("div -21/4", 1'b0, 1'b1, 32'hFFFF_FFEB, 32'd4, 32, 32'hFFFF_FFFB, 1'b0);
        run_op("div minneg/-1", 1'b0, 1'b1, MIN_NEG, 32'hFFFF_FFFF, 32, 32'h8000_0000, 1'b1);
        run_op("div 100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32, 32'hFFFF_FFF2, 1'b0);
        run_op("div by zero", 1'b0, 1'b1, 32'd5, 32'd0, 1, 32'h0, 1'b1);

        // Multiply started, then a divide issued ten edges later.
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        count_rdy(9, cnt);
        check("restart early rdy", 32'(cnt), 32'd0);
        run_op("restart div", 1'b0, 1'b1, 32'd100, 32'd7, 32, 32'd14, 1'b0);
        count_rdy(40, cnt);
        check("restart extra rdy", 32'(cnt), 32'd0);

        run_op("mult+div both", 1'b1, 1'b1, 32'd6, 32'd7, 32, 32'd42, 1'b0);

        // Reset dropped partway through a multiply.
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        count_rdy(14, cnt);
        check("pre-reset rdy", 32'(cnt), 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("mid reset result", data_result, 32'd0);
        check("mid reset exception", 32'(data_exception), 32'd0);
        check("mid reset rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        count_rdy(40, cnt);
        check("post reset rdy", 32'(cnt), 32'd0);

        run_op("mul after reset", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd5, 32, 32'hFFFF_FFEC, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
